// File: rtl/encoder4x2_rr.sv
// encoder4x2_rr
//   Registered 4-to-2 encoder. It is the inverse of the 2x4 active-low
//   decoder: it takes four active-low request lines and returns the 2-bit
//   index {a,b} of one active request. A valid/ready handshake carries the
//   result to the consumer. The selection policy is fixed priority or
//   round-robin.
//
// Parameters
//   PRIO_MODE  0 = fixed priority (index 3 highest), 1 = round-robin that
//              starts after the last granted index.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   en     in   active-low enable: 0 allows a new capture
//   req_n  in   [3:0] active-low requests; bit i low = index i requested
//   a      out  index MSB
//   b      out  index LSB
//   valid  out  {a,b,multi} holds a captured, undelivered code
//   ready  in   consumer takes the code when valid & ready at an edge
//   multi  out  two or more requests were active at capture
module encoder4x2_rr #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req_n,
  output logic       a,
  output logic       b,
  output logic       valid,
  input  logic       ready,
  output logic       multi
);

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  logic       state_q;
  logic [1:0] ptr_q;
  logic [1:0] code_p1;
  logic       multi_p1;
  logic       vld_p1;

  logic [3:0] reqs_p0;
  logic       any_p0;
  logic       hs_p0;
  logic       cap_p0;
  logic [1:0] sel_p0;
  logic       multi_p0;

  // The highest requested index wins.
  function automatic logic [1:0] sel_fixed(input logic [3:0] reqs);
    logic [1:0] idx;
    casez (reqs)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Rotate the request vector so that position 0 is the index after the
  // last grant. The first active bit of the rotated vector gives an offset,
  // and the offset is added back to that start position. The 2-bit sum wraps
  // 3 -> 0 on its own.
  function automatic logic [1:0] sel_rr(input logic [3:0] reqs,
                                        input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [2:0] start;
    logic [7:0] shifted;
    logic [3:0] rot;
    logic [1:0] off;
    dbl     = {reqs, reqs};
    start   = {1'b0, ptr} + 3'd1;
    shifted = dbl >> start;
    rot     = shifted[3:0];
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      default: off = 2'd3;
    endcase
    return ptr + 2'd1 + off;
  endfunction

  // At least two of the four requests are active.
  function automatic logic two_or_more(input logic [3:0] reqs);
    return (reqs[0] & reqs[1]) | (reqs[0] & reqs[2]) | (reqs[0] & reqs[3]) |
           (reqs[1] & reqs[2]) | (reqs[1] & reqs[3]) | (reqs[2] & reqs[3]);
  endfunction

  // ---- stage p0: request decode and selection ----
  always_comb begin
    reqs_p0  = ~req_n;
    any_p0   = |reqs_p0;
    hs_p0    = (state_q == HOLD) && ready;
    // A new code loads from IDLE, or at the same edge as a handshake, so
    // that back-to-back transfers do not lose a cycle.
    cap_p0   = !en && any_p0 && ((state_q == IDLE) || hs_p0);
    if (PRIO_MODE == 1) begin
      sel_p0 = sel_rr(reqs_p0, ptr_q);
    end else begin
      sel_p0 = sel_fixed(reqs_p0);
    end
    multi_p0 = two_or_more(reqs_p0);
  end

  // ---- stage p1: captured code and handshake state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      vld_p1   <= 1'b0;
      code_p1  <= 2'd0;
      multi_p1 <= 1'b0;
    end else if (cap_p0) begin
      state_q  <= HOLD;
      vld_p1   <= 1'b1;
      code_p1  <= sel_p0;
      multi_p1 <= multi_p0;
      // The pointer moves at capture rather than at delivery. The next
      // search therefore already skips a code that is still waiting.
      ptr_q    <= sel_p0;
    end else if (hs_p0) begin
      // The code and multi keep their last values after delivery.
      state_q  <= IDLE;
      vld_p1   <= 1'b0;
    end
  end

  assign a     = code_p1[1];
  assign b     = code_p1[0];
  assign multi = multi_p1;
  assign valid = vld_p1;

endmodule

// File: tb/tb_encoder4x2_rr.sv
module tb_encoder4x2_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req_n;
  logic       ready;

  logic a0, b0, valid0, multi0;
  logic a1, b1, valid1, multi1;

  int tests = 0;
  int fails = 0;

  // Reference model state. The scoreboard queues hold {code, multi}.
  logic       mvalid [2];
  logic [1:0] mptr   [2];
  logic [2:0] mlast  [2];
  logic [2:0] q0 [$];
  logic [2:0] q1 [$];

  always #5 clk = ~clk;

  encoder4x2_rr #(.PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req_n(req_n),
    .a(a0), .b(b0), .valid(valid0), .ready(ready), .multi(multi0)
  );

  encoder4x2_rr #(.PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req_n(req_n),
    .a(a1), .b(b1), .valid(valid1), .ready(ready), .multi(multi1)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_sel(input int m, input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] res;
    res = 2'd0;
    if (m == 0) begin
      for (int i = 0; i < 4; i++) if (r[i]) res = 2'(i);
    end else begin
      for (int k = 4; k >= 1; k--) begin
        int idx;
        idx = (int'(ptr) + k) % 4;
        if (r[idx]) res = 2'(idx);
      end
    end
    return res;
  endfunction

  function automatic logic model_multi(input logic [3:0] r);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (r[i]) n++;
    return n >= 2;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] r;
    r = ~req_n;
    for (int m = 0; m < 2; m++) begin
      logic hs, cap;
      logic [1:0] s;
      logic [2:0] entry;
      hs  = mvalid[m] && ready;
      cap = !en && (r != 4'd0) && (!mvalid[m] || hs);
      if (rst) begin
        mvalid[m] = 1'b0;
        mptr[m]   = 2'd3;
        mlast[m]  = 3'd0;
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        if (hs) begin
          if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (cap) begin
          s = model_sel(m, r, mptr[m]);
          entry = {s, model_multi(r)};
          if (m == 0) q0.push_back(entry); else q1.push_back(entry);
          mlast[m]  = entry;
          mvalid[m] = 1'b1;
          if (m == 1) mptr[m] = s;
        end else if (hs) begin
          mvalid[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [2:0] e0, e1;
    e0 = (mvalid[0] && q0.size() > 0) ? q0[0] : mlast[0];
    e1 = (mvalid[1] && q1.size() > 0) ? q1[0] : mlast[1];
    check("valid0", {3'b0, valid0}, {3'b0, mvalid[0]});
    check("code0",  {1'b0, a0, b0, multi0}, {1'b0, e0});
    check("valid1", {3'b0, valid1}, {3'b0, mvalid[1]});
    check("code1",  {1'b0, a1, b1, multi1}, {1'b0, e1});
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic rd);
    rst = r; en = e; req_n = rq; ready = rd;
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_n = 4'hF; ready = 1'b0;
    mvalid[0] = 1'b0; mvalid[1] = 1'b0;
    mptr[0] = 2'd3; mptr[1] = 2'd3;
    mlast[0] = 3'd0; mlast[1] = 3'd0;

    // Reset, then idle with no requests.
    step(1, 0, 4'hF, 0);
    step(1, 0, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'hF, 0);
      check("idle_dir", {a0, b0, valid0, multi0}, 4'b0000);
    end

    // Single request at index 2, held while en is high, then delivered.
    step(0, 0, 4'b1011, 0);
    check("single_dir", {a0, b0, valid0, multi0}, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'hF, 0);
      check("hold_dir", {a0, b0, valid0, multi0}, 4'b1010);
    end
    step(0, 1, 4'hF, 1);
    check("drop_dir", {3'b0, valid0}, 4'b0000);

    // Fixed priority: 3 beats 0. A back-to-back capture of {1,0} yields 1.
    step(0, 0, 4'b0110, 0);
    check("prio3_dir", {a0, b0, valid0, multi0}, 4'b1111);
    step(0, 0, 4'b1100, 1);
    check("prio1_dir", {a0, b0, valid0, multi0}, 4'b0111);
    step(0, 1, 4'hF, 1);

    // Enable gating.
    step(0, 1, 4'b1110, 0);
    step(0, 1, 4'b1110, 0);
    check("engate_dir", {3'b0, valid0}, 4'b0000);
    step(0, 0, 4'b1110, 0);
    check("enopen_dir", {a0, b0, valid0, multi0}, 4'b0010);
    step(0, 1, 4'hF, 1);

    // Round-robin from reset with every request active and ready held high.
    step(1, 0, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] want;
      want = 2'(i % 4);
      step(0, 0, 4'b0000, 1);
      check("rr_dir", {a1, b1, valid1, multi1}, {want, 2'b11});
    end
    step(0, 1, 4'hF, 1);

    // Reset while a code is pending discards it. The pointer restarts.
    step(0, 0, 4'b0111, 0);
    check("pend_dir", {a1, b1, valid1, multi1}, 4'b1110);
    step(1, 0, 4'hF, 0);
    check("rstmid_dir", {a1, b1, valid1, multi1}, 4'b0000);
    step(0, 0, 4'b0000, 0);
    check("rrfirst_dir", {a1, b1, valid1, multi1}, 4'b0011);
    step(0, 1, 4'hF, 1);

    // Mixed traffic checked against the model alone.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 0 ? 1'b0 : 1'b1,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
